io_bus_arbiter: RTL and testbench

Two-master arbiter in front of the IO register block (#B000–#BFFF PIO, extension, VIA, VGA colour registers). Shares one IO register bus between the 6502 core (requester 0) and a host/debug master (requester 1). Each access takes one bus cycle. Read data is captured and returned with a valid strobe. Sits between the CPU/debug muxing and the IO block's address/Din/WE/Dout port.

---
 rtl/io_arb_pkg.sv | 20 ++
 rtl/io_bus_arbiter_rr_arb2.sv | 38 +++
 rtl/io_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_io_bus_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/io_arb_pkg.sv
// Shared types and constants for the two-master IO register bus arbiter.
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    // Requester index: 0 = 6502 core, 1 = host/debug master.
    typedef logic req_idx_t;

    localparam logic [15:0] IO_IDLE_ADDR = 16'h0000;
    localparam logic [7:0]  IO_IDLE_DATA = 8'h00;

    function automatic logic [1:0] idx_to_onehot(input req_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_arb2.sv
// Two-way arbiter: combinational winner from req and the last grant,
// with the last-grant register advancing only on an enabled grant.
module rr_arb2
    import io_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] win,
    output req_idx_t   win_idx
);

    req_idx_t last_grant_q;

    always_comb begin
        win_idx = 1'b0;
        unique case (req)
            2'b01:   win_idx = 1'b0;
            2'b10:   win_idx = 1'b1;
            2'b11:   win_idx = FIXED_PRIO ? 1'b0 : ~last_grant_q;
            default: win_idx = 1'b0;
        endcase
        win = (req == 2'b00) ? 2'b00 : idx_to_onehot(win_idx);
    end

    // Reset to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (srst) begin
            last_grant_q <= 1'b1;
        end else if (en && (req != 2'b00)) begin
            last_grant_q <= win_idx;
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the IO register bus between the CPU (req 0) and a debug master
// (req 1): one bus cycle per access, read data returned one cycle later.
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic        we0,
    input  logic        we1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [7:0]  rdata,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [15:0] io_address,
    output logic [7:0]  io_din,
    output logic        io_we,
    input  logic [7:0]  io_dout
);

    arb_state_e  state_q, state_d;
    logic [15:0] io_address_q, io_address_d;
    logic [7:0]  io_din_q, io_din_d;
    logic        io_we_q, io_we_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [7:0]  rdata_q, rdata_d;
    req_idx_t    cur_idx_q, cur_idx_d;

    logic [1:0]  req;
    logic [1:0]  win;
    req_idx_t    win_idx;
    logic        arb_en;

    assign req    = {req1, req0};
    assign arb_en = (state_q != ACCESS);

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk     (clk),
        .srst    (reset),
        .req     (req),
        .en      (arb_en),
        .win     (win),
        .win_idx (win_idx)
    );

    always_comb begin
        state_d      = state_q;
        io_address_d = IO_IDLE_ADDR;
        io_din_d     = IO_IDLE_DATA;
        io_we_d      = 1'b0;
        gnt_d        = 2'b00;
        rvalid_d     = 2'b00;
        rdata_d      = rdata_q;
        cur_idx_d    = cur_idx_q;
        unique case (state_q)
            ACCESS: begin
                state_d = DONE;
                if (!io_we_q) begin
                    rdata_d  = io_dout;
                    rvalid_d = idx_to_onehot(cur_idx_q);
                end
            end
            IDLE, DONE: begin
                // DONE re-arbitrates so back-to-back requests get one access per 2 cycles.
                if (req != 2'b00) begin
                    state_d      = ACCESS;
                    cur_idx_d    = win_idx;
                    io_address_d = win_idx ? addr1 : addr0;
                    io_din_d     = win_idx ? wdata1 : wdata0;
                    io_we_d      = win_idx ? we1 : we0;
                    gnt_d        = win;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            io_address_q <= IO_IDLE_ADDR;
            io_din_q     <= IO_IDLE_DATA;
            io_we_q      <= 1'b0;
            gnt_q        <= 2'b00;
            rvalid_q     <= 2'b00;
            rdata_q      <= 8'h00;
            cur_idx_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            io_address_q <= io_address_d;
            io_din_q     <= io_din_d;
            io_we_q      <= io_we_d;
            gnt_q        <= gnt_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            cur_idx_q    <= cur_idx_d;
        end
    end

    assign gnt0       = gnt_q[0];
    assign gnt1       = gnt_q[1];
    assign rvalid0    = rvalid_q[0];
    assign rvalid1    = rvalid_q[1];
    assign rdata      = rdata_q;
    assign io_address = io_address_q;
    assign io_din     = io_din_q;
    assign io_we      = io_we_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share stimulus.
module tb_io_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic [7:0]  io_dout_val;

    logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, io_we_a;
    logic [7:0]  rdata_a, io_din_a;
    logic [15:0] io_address_a;
    logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, io_we_b;
    logic [7:0]  rdata_b, io_din_b;
    logic [15:0] io_address_b;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    io_bus_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .rdata(rdata_a),
        .rvalid0(rvalid0_a), .rvalid1(rvalid1_a),
        .io_address(io_address_a), .io_din(io_din_a), .io_we(io_we_a),
        .io_dout(io_dout_val)
    );

    io_bus_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .rdata(rdata_b),
        .rvalid0(rvalid0_b), .rvalid1(rvalid1_b),
        .io_address(io_address_b), .io_din(io_din_b), .io_we(io_we_b),
        .io_dout(io_dout_val)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] exp_gnt;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 16'h0000; addr1 = 16'h0000; wdata0 = 8'h00; wdata1 = 8'h00;
        io_dout_val = 8'hA5;
        step();
        step();

        // reset state
        chk("rst_gnt", {gnt1_a, gnt0_a, gnt1_b, gnt0_b}, 4'b0000);
        chk("rst_rvalid", {rvalid1_a, rvalid0_a, rvalid1_b, rvalid0_b}, 4'b0000);
        chk("rst_rdata", rdata_a, 8'h00);
        chk("rst_addr", io_address_a, 16'h0000);
        chk("rst_din_we", {io_din_a, io_we_a}, 9'h000);
        reset = 1'b0;

        // single read by requester 0
        req0 = 1'b1; addr0 = 16'hB001; we0 = 1'b0;
        step();
        chk("rd_gnt", {gnt1_a, gnt0_a}, 2'b01);
        chk("rd_addr", io_address_a, 16'hB001);
        chk("rd_we", io_we_a, 1'b0);
        $display("txn read  req0 addr=%h", io_address_a);
        req0 = 1'b0;
        step();
        chk("rd_rvalid", {rvalid1_a, rvalid0_a}, 2'b01);
        chk("rd_rdata", rdata_a, 8'hA5);
        chk("rd_gnt_off", {gnt1_a, gnt0_a}, 2'b00);
        chk("rd_bus_idle", io_address_a, 16'h0000);
        step();
        chk("rd_rvalid_off", {rvalid1_a, rvalid0_a}, 2'b00);

        // single write by requester 1
        req1 = 1'b1; addr1 = 16'hBC02; we1 = 1'b1; wdata1 = 8'h3F;
        step();
        chk("wr_gnt", {gnt1_a, gnt0_a}, 2'b10);
        chk("wr_bus", {io_address_a, io_din_a, io_we_a}, {16'hBC02, 8'h3F, 1'b1});
        $display("txn write req1 addr=%h data=%h", io_address_a, io_din_a);
        req1 = 1'b0; we1 = 1'b0;
        step();
        chk("wr_we_off", io_we_a, 1'b0);
        chk("wr_no_rvalid", {rvalid1_a, rvalid0_a}, 2'b00);
        chk("wr_bus_idle", io_address_a, 16'h0000);
        chk("wr_rdata_hold", rdata_a, 8'hA5);

        // both requesters held for six accesses
        req0 = 1'b1; addr0 = 16'hB010;
        req1 = 1'b1; addr1 = 16'hB020;
        for (int k = 0; k < 6; k++) begin
            step();
            exp_gnt = (k % 2 == 1) ? 2'b10 : 2'b01;
            chk("rr_gnt", {gnt1_a, gnt0_a}, exp_gnt);
            chk("rr_addr", io_address_a, (k % 2 == 1) ? 16'hB020 : 16'hB010);
            chk("fp_gnt", {gnt1_b, gnt0_b}, 2'b01);
            $display("txn dual k=%0d rr_gnt=%b fp_gnt=%b", k, {gnt1_a, gnt0_a}, {gnt1_b, gnt0_b});
            io_dout_val = 8'h10 + 8'(k);
            step();
            chk("rr_gap", {gnt1_a, gnt0_a}, 2'b00);
            chk("rr_rvalid", {rvalid1_a, rvalid0_a}, exp_gnt);
            chk("rr_rdata", rdata_a, 8'h10 + 8'(k));
            chk("fp_rvalid", {rvalid1_b, rvalid0_b}, 2'b01);
        end
        req0 = 1'b0;
        step();
        chk("tail_gnt_rr", {gnt1_a, gnt0_a}, 2'b10);
        chk("tail_gnt_fp", {gnt1_b, gnt0_b}, 2'b10);
        io_dout_val = 8'h77;
        req1 = 1'b0;
        step();
        chk("tail_rvalid_fp", {rvalid1_b, rvalid0_b}, 2'b10);
        chk("tail_rdata_fp", rdata_b, 8'h77);
        step();
        chk("tail_idle", {gnt1_a, gnt0_a, gnt1_b, gnt0_b}, 4'b0000);

        // reset during the access cycle of a read
        req0 = 1'b1; addr0 = 16'hB003; we0 = 1'b0;
        step();
        chk("rstacc_gnt", {gnt1_a, gnt0_a}, 2'b01);
        reset = 1'b1; req0 = 1'b0; io_dout_val = 8'hEE;
        step();
        chk("rstacc_rvalid", {rvalid1_a, rvalid0_a, rvalid1_b, rvalid0_b}, 4'b0000);
        chk("rstacc_rdata", rdata_a, 8'h00);
        chk("rstacc_bus", {io_address_a, io_we_a}, 17'h00000);
        reset = 1'b0;
        step();
        chk("rstacc_noreplay", {gnt1_a, gnt0_a, rvalid1_a, rvalid0_a}, 4'b0000);

        // idle bus
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_addr", io_address_a, 16'h0000);
            chk("idle_we", {io_we_a, io_we_b}, 2'b00);
            chk("idle_pulses", {gnt1_a, gnt0_a, rvalid1_a, rvalid0_a, gnt1_b, gnt0_b}, 6'b000000);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
